// File: rtl/reaction_pkg.sv
// reaction_pkg
// Shared definitions for the reaction-timer controller slice.
//   state_t    : FSM state encoding (3 bits)
//   LFSR_SEED  : value the pseudo-random generator restarts from on reset
//   LFSR_TAPS  : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   lfsr_next  : one step of the 16-bit Fibonacci LFSR
package reaction_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_RAND = 3'd1,
      MEASURE   = 3'd2,
      DONE      = 3'd3,
      CHEAT     = 3'd4
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Shift left and feed the XOR of the tapped bits into bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] value);
      return {value[14:0], ^(value & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/reaction_ctrl_if.sv
// reaction_ctrl_if
// Groups the button pulses and the status/result outputs of the controller.
//   clear_tick, start_tick, stop_tick : one-cycle debounced button pulses
//   stim_led, result[9:0], result_valid, timeout, cheat, busy : controller outputs
// master : button/display side (drives ticks, observes status)
// slave  : the controller itself
interface reaction_ctrl_if;

   logic       clear_tick;
   logic       start_tick;
   logic       stop_tick;
   logic       stim_led;
   logic [9:0] result;
   logic       result_valid;
   logic       timeout;
   logic       cheat;
   logic       busy;

   modport master (
      output clear_tick, start_tick, stop_tick,
      input  stim_led, result, result_valid, timeout, cheat, busy
   );

   modport slave (
      input  clear_tick, start_tick, stop_tick,
      output stim_led, result, result_valid, timeout, cheat, busy
   );

endinterface

// File: rtl/reaction_ctrl_ms_prescaler.sv
// ms_prescaler
// Divides clk down to a one-cycle ms_tick every CLK_PER_MS cycles.
//   clk     : system clock
//   reset   : asynchronous, active-high
//   restart : synchronous, forces the count back to 0
//   ms_tick : high on the cycle where the count wraps (count == CLK_PER_MS-1)
module ms_prescaler #(
   parameter int CLK_PER_MS = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic ms_tick
);

   localparam int          CW   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

   logic [CW-1:0] count;

   assign ms_tick = (count == LAST);

   // Free-running modulo counter; a restart aligns the next tick to a
   // full millisecond after the restart edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (restart || ms_tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl
// Sequencing controller for the reaction timer: start -> pseudo-random wait ->
// stimulus LED on -> count ms until stop (or saturate at MAX_MS).
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : reaction_ctrl_if.slave (button ticks in, result/status out)
// Parameters: CLK_PER_MS, MAX_MS (<= 1023), RAND_MIN_MS.
// Optional macro REACTION_CHEAT_DETECT_EN: a stop press during the random wait
// moves to CHEAT and raises cheat; without it that press is ignored.
module reaction_ctrl
   import reaction_pkg::*;
#(
   parameter int CLK_PER_MS  = 100000,
   parameter int MAX_MS      = 1000,
   parameter int RAND_MIN_MS = 2000
) (
   input  logic            clk,
   input  logic            reset,
   reaction_ctrl_if.slave  bus
);

   localparam logic [13:0] RAND_MIN = 14'(RAND_MIN_MS);
   localparam logic [13:0] MAX_CNT  = 14'(MAX_MS);

   state_t      state, state_n;
   logic [15:0] lfsr;
   logic [13:0] ms_cnt, ms_cnt_n;
   logic [13:0] delay, delay_n;
   logic [13:0] ms_inc;
   logic [13:0] start_delay;
   logic [9:0]  result_n;
   logic        valid_n, timeout_n, cheat_n;
   logic        ms_tick;
   logic        restart;

   // Every state change realigns the millisecond grid to the transition edge.
   assign restart     = (state_n != state);
   assign ms_inc      = ms_cnt + 14'd1;
   assign start_delay = RAND_MIN + {1'b0, lfsr[12:0]};

   ms_prescaler #(.CLK_PER_MS(CLK_PER_MS)) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .ms_tick (ms_tick)
   );

   // State and datapath registers; stim_led and busy are registered from the
   // next state so they change on the same edge as the state itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         lfsr             <= LFSR_SEED;
         ms_cnt           <= '0;
         delay            <= '0;
         bus.result       <= '0;
         bus.result_valid <= 1'b0;
         bus.timeout      <= 1'b0;
         bus.stim_led     <= 1'b0;
         bus.busy         <= 1'b0;
      end else begin
         state            <= state_n;
         lfsr             <= lfsr_next(lfsr);
         ms_cnt           <= ms_cnt_n;
         delay            <= delay_n;
         bus.result       <= result_n;
         bus.result_valid <= valid_n;
         bus.timeout      <= timeout_n;
         bus.stim_led     <= (state_n == MEASURE);
         bus.busy         <= (state_n == WAIT_RAND) || (state_n == MEASURE);
      end
   end

`ifdef REACTION_CHEAT_DETECT_EN
   // Early-stop flag only exists when cheat detection is compiled in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.cheat <= 1'b0;
      end else begin
         bus.cheat <= cheat_n;
      end
   end
`else
   assign bus.cheat = 1'b0;
`endif

   // Next-state logic. Clear overrides everything; in MEASURE stop is tested
   // before the timeout so a stop on the saturating tick reports MAX_MS-1.
   // Starting from IDLE, DONE or CHEAT is the same action: wipe the previous
   // result and flags, latch a fresh random delay.
   always_comb begin
      state_n   = state;
      ms_cnt_n  = ms_cnt;
      delay_n   = delay;
      result_n  = bus.result;
      valid_n   = bus.result_valid;
      timeout_n = bus.timeout;
      cheat_n   = bus.cheat;

      if (bus.clear_tick) begin
         state_n   = IDLE;
         ms_cnt_n  = '0;
         result_n  = '0;
         valid_n   = 1'b0;
         timeout_n = 1'b0;
         cheat_n   = 1'b0;
      end else begin
         case (state)
            IDLE, DONE
`ifdef REACTION_CHEAT_DETECT_EN
            , CHEAT
`endif
            : begin
               if (bus.start_tick) begin
                  state_n   = WAIT_RAND;
                  delay_n   = start_delay;
                  ms_cnt_n  = '0;
                  result_n  = '0;
                  valid_n   = 1'b0;
                  timeout_n = 1'b0;
                  cheat_n   = 1'b0;
               end
            end
            WAIT_RAND: begin
`ifdef REACTION_CHEAT_DETECT_EN
               if (bus.stop_tick) begin
                  state_n  = CHEAT;
                  cheat_n  = 1'b1;
                  result_n = '0;
                  ms_cnt_n = '0;
               end else
`endif
               if (ms_tick) begin
                  if (ms_inc == delay) begin
                     state_n  = MEASURE;
                     ms_cnt_n = '0;
                  end else begin
                     ms_cnt_n = ms_inc;
                  end
               end
            end
            MEASURE: begin
               if (bus.stop_tick) begin
                  state_n  = DONE;
                  result_n = ms_cnt[9:0];
                  valid_n  = 1'b1;
               end else if (ms_tick) begin
                  if (ms_inc == MAX_CNT) begin
                     state_n   = DONE;
                     result_n  = MAX_CNT[9:0];
                     valid_n   = 1'b1;
                     timeout_n = 1'b1;
                  end else begin
                     ms_cnt_n = ms_inc;
                  end
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl
// Self-checking bench for reaction_ctrl with CLK_PER_MS=4, MAX_MS=20 and a
// short RAND_MIN_MS so waits stay brief. An independent LFSR model predicts
// the random delay; starts are timed to windows where the delay is short.
// Expected measurement results go into a scoreboard queue when stop (or no
// stop) is decided and are popped when result_valid appears.
// Compile with +define+REACTION_CHEAT_DETECT_EN to exercise the cheat path.
module tb_reaction_ctrl;

   localparam int CPM      = 4;
   localparam int MAXMS    = 20;
   localparam int RMIN     = 10;
   localparam int SMALL    = 60;

   typedef struct packed {
      logic [9:0] res;
      logic       to;
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] lfsr_model;
   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;

   reaction_ctrl_if bus ();

   reaction_ctrl #(
      .CLK_PER_MS  (CPM),
      .MAX_MS      (MAXMS),
      .RAND_MIN_MS (RMIN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference LFSR: taps 16,14,13,11 written out bit by bit.
   always @(posedge clk or posedge reset) begin
      if (reset) lfsr_model <= 16'hACE1;
      else       lfsr_model <= {lfsr_model[14:0],
                                lfsr_model[15] ^ lfsr_model[13] ^ lfsr_model[12] ^ lfsr_model[10]};
   end

   function automatic logic [14:0] outs();
      return {bus.stim_led, bus.result, bus.result_valid, bus.timeout, bus.cheat, bus.busy};
   endfunction

   // Waits for a cycle where the predicted delay is short, then pulses start.
   // Returns at the negedge just after the start edge.
   task automatic do_start(output int d, output bit ok);
      int n = 0;
      ok = 1'b0;
      d  = 0;
      while (n < 3000 && !ok) begin
         if (int'(lfsr_model[12:0]) < SMALL) ok = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      d = RMIN + int'(lfsr_model[12:0]);
      bus.start_tick = 1'b1;
      @(negedge clk);
      bus.start_tick = 1'b0;
   endtask

   // Counts negedges until stim_led is seen; cnt-1 is the edge offset.
   task automatic wait_stim(input int cnt_in, output int cnt, output bit ok);
      cnt = cnt_in;
      while (!bus.stim_led && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      ok = bus.stim_led;
   endtask

   task automatic test_reset();
      bus.clear_tick = 1'b0;
      bus.start_tick = 1'b0;
      bus.stop_tick  = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (outs() !== 15'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h want 0", outs());
      end
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if (outs() !== 15'd0) begin
            errors++;
            $display("[TB] FAIL idle_outputs cycle %0d: got %h want 0", i, outs());
         end
      end
   endtask

   task automatic test_stop_measure();
      int d, cnt, k;
      bit ok, ok2;
      exp_t e;
      do_start(d, ok);
      checks++;
      if (bus.busy !== 1'b1 || bus.stim_led !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busy_after_start: got busy=%b stim=%b want 1/0", bus.busy, bus.stim_led);
      end
      wait_stim(1, cnt, ok2);
      checks++;
      if (!ok || !ok2 || (cnt - 1) != d * CPM) begin
         errors++;
         $display("[TB] FAIL wait_length: got %0d cycles want %0d", cnt - 1, d * CPM);
      end
      k = 30;
      repeat (k - 1) @(negedge clk);
      bus.stop_tick = 1'b1;
      sb.push_back(exp_t'{10'((k - 1) / CPM), 1'b0});
      @(negedge clk);
      bus.stop_tick = 1'b0;
      checks++;
      if (bus.stim_led !== 1'b0 || bus.busy !== 1'b0 || bus.result_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stop_flags: got stim=%b busy=%b valid=%b want 0/0/1",
                  bus.stim_led, bus.busy, bus.result_valid);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("[TB] FAIL stop_result: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (bus.result !== e.res || bus.timeout !== e.to) begin
            errors++;
            $display("[TB] FAIL stop_result: got %0d/%b want %0d/%b", bus.result, bus.timeout, e.res, e.to);
         end
      end
   endtask

   task automatic test_timeout();
      int d, cnt;
      bit ok, ok2;
      exp_t e;
      do_start(d, ok);
      wait_stim(1, cnt, ok2);
      checks++;
      if (!ok || !ok2 || (cnt - 1) != d * CPM) begin
         errors++;
         $display("[TB] FAIL timeout_wait_length: got %0d cycles want %0d", cnt - 1, d * CPM);
      end
      sb.push_back(exp_t'{10'(MAXMS), 1'b1});
      cnt = 0;
      while (!bus.result_valid && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      checks++;
      if (cnt != MAXMS * CPM) begin
         errors++;
         $display("[TB] FAIL timeout_latency: got %0d cycles want %0d", cnt, MAXMS * CPM);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("[TB] FAIL timeout_result: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (bus.result !== e.res || bus.timeout !== e.to || bus.stim_led !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_result: got %0d/%b stim=%b busy=%b want %0d/%b stim=0 busy=0",
                     bus.result, bus.timeout, bus.stim_led, bus.busy, e.res, e.to);
         end
      end
   endtask

   // Stop lands on the same edge as the saturating ms tick: stop wins.
   task automatic test_back_to_back();
      int d, cnt, k;
      bit ok, ok2;
      exp_t e;
      do_start(d, ok);
      checks++;
      if (!ok || bus.result !== 10'd0 || bus.result_valid !== 1'b0 || bus.timeout !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL restart_from_done: got res=%0d valid=%b to=%b busy=%b want 0/0/0/1",
                  bus.result, bus.result_valid, bus.timeout, bus.busy);
      end
      wait_stim(1, cnt, ok2);
      checks++;
      if (!ok2 || (cnt - 1) != d * CPM) begin
         errors++;
         $display("[TB] FAIL b2b_wait_length: got %0d cycles want %0d", cnt - 1, d * CPM);
      end
      k = MAXMS * CPM;
      repeat (k - 1) @(negedge clk);
      bus.stop_tick = 1'b1;
      sb.push_back(exp_t'{10'((k - 1) / CPM), 1'b0});
      @(negedge clk);
      bus.stop_tick = 1'b0;
      checks++;
      if (sb.size() == 0 || bus.result_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stop_at_max: valid=%b queue=%0d want valid=1", bus.result_valid, sb.size());
      end else begin
         e = sb.pop_front();
         if (bus.result !== e.res || bus.timeout !== e.to) begin
            errors++;
            $display("[TB] FAIL stop_at_max: got %0d/%b want %0d/%b", bus.result, bus.timeout, e.res, e.to);
         end
      end
   endtask

   task automatic test_wait_stop();
      int d, cnt;
      bit ok, ok2;
      exp_t e;
      do_start(d, ok);
      repeat (11) @(negedge clk);
      bus.stop_tick = 1'b1;
      @(negedge clk);
      bus.stop_tick = 1'b0;
`ifdef REACTION_CHEAT_DETECT_EN
      checks++;
      if (bus.cheat !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 10'd0 || bus.stim_led !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cheat_detect: got cheat=%b busy=%b res=%0d stim=%b want 1/0/0/0",
                  bus.cheat, bus.busy, bus.result, bus.stim_led);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (bus.cheat !== 1'b1 || bus.stim_led !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cheat_hold: got cheat=%b stim=%b want 1/0", bus.cheat, bus.stim_led);
      end
      bus.clear_tick = 1'b1;
      @(negedge clk);
      bus.clear_tick = 1'b0;
      checks++;
      if (outs() !== 15'd0) begin
         errors++;
         $display("[TB] FAIL cheat_clear: got %h want 0", outs());
      end
`else
      checks++;
      if (bus.cheat !== 1'b0 || bus.busy !== 1'b1 || bus.stim_led !== 1'b0) begin
         errors++;
         $display("[TB] FAIL early_stop_ignored: got cheat=%b busy=%b stim=%b want 0/1/0",
                  bus.cheat, bus.busy, bus.stim_led);
      end
      wait_stim(13, cnt, ok2);
      checks++;
      if (!ok || !ok2 || (cnt - 1) != d * CPM) begin
         errors++;
         $display("[TB] FAIL early_stop_wait_length: got %0d cycles want %0d", cnt - 1, d * CPM);
      end
      repeat (5) @(negedge clk);
      bus.stop_tick = 1'b1;
      sb.push_back(exp_t'{10'(5 / CPM), 1'b0});
      @(negedge clk);
      bus.stop_tick = 1'b0;
      checks++;
      if (sb.size() == 0 || bus.result_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL early_stop_result: valid=%b want 1", bus.result_valid);
      end else begin
         e = sb.pop_front();
         if (bus.result !== e.res || bus.timeout !== e.to) begin
            errors++;
            $display("[TB] FAIL early_stop_result: got %0d/%b want %0d/%b", bus.result, bus.timeout, e.res, e.to);
         end
      end
`endif
   endtask

   task automatic test_clear_stop();
      int d, cnt;
      bit ok, ok2;
      do_start(d, ok);
      wait_stim(1, cnt, ok2);
      checks++;
      if (!ok || !ok2) begin
         errors++;
         $display("[TB] FAIL clear_setup: stim_led never rose, got %0d cycles", cnt - 1);
      end
      repeat (10) @(negedge clk);
      bus.clear_tick = 1'b1;
      bus.stop_tick  = 1'b1;
      @(negedge clk);
      bus.clear_tick = 1'b0;
      bus.stop_tick  = 1'b0;
      checks++;
      if (outs() !== 15'd0) begin
         errors++;
         $display("[TB] FAIL clear_beats_stop: got %h want 0", outs());
      end
      repeat (30) @(negedge clk);
      checks++;
      if (outs() !== 15'd0) begin
         errors++;
         $display("[TB] FAIL clear_stays_idle: got %h want 0", outs());
      end
   endtask

   task automatic test_reset_mid();
      int d, cnt;
      bit ok, ok2;
      do_start(d, ok);
      wait_stim(1, cnt, ok2);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (outs() !== 15'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %h want 0", outs());
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      do_start(d, ok);
      wait_stim(1, cnt, ok2);
      checks++;
      if (!ok || !ok2 || (cnt - 1) != d * CPM) begin
         errors++;
         $display("[TB] FAIL reseed_delay: got %0d cycles want %0d", cnt - 1, d * CPM);
      end
      bus.clear_tick = 1'b1;
      @(negedge clk);
      bus.clear_tick = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stop_measure();
      test_timeout();
      test_back_to_back();
      test_wait_stop();
      test_clear_stop();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reaction_ctrl.md
# reaction_ctrl

Sequencing controller for the reaction-timer design. It takes the single-cycle `db_tick` pulses from the three push-button debouncers (clear, start, stop) and runs the test. After start it waits a pseudo-random delay, then lights the stimulus LED and counts milliseconds until stop. It sits between the debouncer instances and the display driver, and presents a registered millisecond result plus status flags.

## Interface
- `CLK_PER_MS`, default 100000: clk cycles per millisecond (100 MHz clock).
- `MAX_MS`, default 1000: measurement timeout in ms; result saturates here.
- `RAND_MIN_MS`, default 2000: minimum random wait in ms.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `clear_tick`  in  1  one-cycle debounced pulse from the clear button.
- `start_tick`  in  1  one-cycle debounced pulse from the start button.
- `stop_tick`  in  1  one-cycle debounced pulse from the stop button.
- `stim_led`  out  1  stimulus lamp; high only in MEASURE.
- `result`  out  10  reaction time in ms, 0..MAX_MS; holds until the next start or clear.
- `result_valid`  out  1  high in DONE.
- `timeout`  out  1  high in DONE when the result saturated at MAX_MS.
- `cheat`  out  1  high in CHEAT state (macro-dependent).
- `busy`  out  1  high in WAIT_RAND or MEASURE.

## Operation
- Reset values: state IDLE, all outputs 0, prescaler 0, ms counter 0, LFSR = 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It is free-running and advances every cycle from reset.
- Prescaler: counts 0..CLK_PER_MS-1 and wraps. `ms_tick` is asserted on the wrap cycle. The prescaler clears to 0 on every state change.
- Input priority in the same cycle: `clear_tick` > `stop_tick` > `start_tick`.
- Any state, on `clear_tick`: go to IDLE, `result` = 0, all flags 0.
- IDLE, on `start_tick`: capture `delay = RAND_MIN_MS + lfsr[12:0]` (14-bit, range 2000..10191), clear the ms counter, go to WAIT_RAND.
- WAIT_RAND: the ms counter increments on each `ms_tick`.
  - When the ms counter equals `delay` after an increment, clear the ms counter and go to MEASURE.
  - `start_tick` is ignored.
- MEASURE: `stim_led` = 1, and the ms counter increments on each `ms_tick`.
  - On `stop_tick`: `result` = ms counter (completed ms), go to DONE.
  - If the counter reaches MAX_MS: `result` = MAX_MS, `timeout` = 1, go to DONE.
  - If `stop_tick` and the MAX_MS increment occur in the same cycle, `stop_tick` wins and `result` = MAX_MS-1.
- DONE, on `start_tick`: clear `result`, `result_valid` and `timeout`, then proceed exactly as the IDLE start.
- CHEAT, on `start_tick`: clear `cheat`, then proceed as the IDLE start.
- Width rules: the ms counter is 14 bits and is shared by the wait and measure phases. `result` is the low 10 bits. MAX_MS must not exceed 1023.

## Timing
- All outputs are registered and update on the clk edge after the triggering input cycle.
- Start at edge t: `busy` = 1 from t+1.
- Wait completes at the edge where the delay-th `ms_tick` is consumed: `stim_led` = 1 and `busy` stays 1 from that edge.
- Wait length: exactly `delay` × CLK_PER_MS cycles after the start edge, ±1 cycle for the prescaler restart.
- Stop at edge s in MEASURE: `stim_led` = 0, `result_valid` = 1 and `busy` = 0 from s+1.
- Reset mid-operation: immediate return to reset values, and the LFSR reseeds.

## Configuration
- `REACTION_CHEAT_DETECT_EN` defined:
  - `stop_tick` in WAIT_RAND goes to CHEAT with `cheat` = 1, `busy` = 0, `result` = 0.
  - CHEAT exits only on clear or start.
- Not defined:
  - `stop_tick` in WAIT_RAND is ignored.
  - The CHEAT state is not compiled in, and `cheat` is tied to 0.

## Structure
- Shared package `reaction_pkg` holds:
  - the state encoding localparams: IDLE, WAIT_RAND, MEASURE, DONE, CHEAT (3 bits);
  - the LFSR seed 16'hACE1;
  - the tap mask.
- One sub-module, `ms_prescaler`: a parameterised CLK_PER_MS counter with a synchronous `restart` input and an `ms_tick` output.
- The LFSR, the FSM and the result register stay in `reaction_ctrl`.

## Test plan
All scenarios use CLK_PER_MS = 4 and MAX_MS = 20; the bench models the LFSR to predict `delay`.
- Reset then idle for 50 cycles -> all outputs 0 and the state stays IDLE.
- Start pulse, then stop pulse 7 ms after `stim_led` rises -> `result` = 7, `result_valid` = 1, `timeout` = 0, `stim_led` = 0 the next cycle.
- Start pulse with no stop -> `timeout` = 1, `result` = 20, exactly 80 cycles after `stim_led` rose.
- Stop pulse 3 ms into WAIT_RAND:
  - with the macro -> `cheat` = 1, `busy` = 0;
  - without it -> no change, and the measurement completes normally.
- `clear_tick` and `stop_tick` in the same cycle during MEASURE -> IDLE, `result` = 0, `result_valid` = 0.
- Reset asserted mid-MEASURE, then released and start pulsed -> `delay` matches a fresh LFSR from 16'hACE1.
